// File: rtl/axi_reg_pkg.sv
// Shared response codes, channel FSM encodings and a constant-foldable clog2
// for the AXI4-Lite register bank.
package axi_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Maps a byte address onto a register index and flags whether it hits the bank.
module axi_lite_addr_decode
  import axi_reg_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8,
  localparam int IDX_W         = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS)
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]          idx_o,
  output logic                      in_range_o
);

  localparam int ADDR_LSB = clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_TOP  = ADDR_LSB + IDX_W;

  logic [AXI_ADDR_WIDTH-1:0] upper;
  logic [31:0]               idx_ext;
  logic                      unused_lsbs;

  assign idx_o   = addr_i[ADDR_LSB +: IDX_W];
  assign upper   = addr_i >> IDX_TOP;
  assign idx_ext = 32'(idx_o);

  // Aliases above the index field are rejected rather than wrapped.
  assign in_range_o  = (upper == '0) && (idx_ext < 32'(NUM_REGS));
  assign unused_lsbs = ^addr_i[ADDR_LSB-1:0];

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: control registers written by software, status
// registers sampled from the fabric, with per-register write/read strobes.
module axi_lite_reg_bank
  import axi_reg_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                wr_pulse,
  output logic [NUM_REGS-1:0]                rd_pulse
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS);

  logic                      ready_en_q;
  wr_state_e                 wr_state_q, wr_state_d;
  rd_state_e                 rd_state_q, rd_state_d;
  logic                      aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0] status_arr [NUM_REGS];
  logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
  logic                      aw_hs, w_hs, ar_hs, wr_commit, b_done;
  logic [IDX_W-1:0]          w_idx, r_idx;
  logic                      w_in_range, r_in_range;
  logic [1:0]                w_resp, r_resp;
  logic [AXI_DATA_WIDTH-1:0] r_value;

  axi_lite_addr_decode #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .NUM_REGS      (NUM_REGS)
  ) u_wr_dec (
    .addr_i    (awaddr_q),
    .idx_o     (w_idx),
    .in_range_o(w_in_range)
  );

  axi_lite_addr_decode #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .NUM_REGS      (NUM_REGS)
  ) u_rd_dec (
    .addr_i    (S_AXI_ARADDR),
    .idx_o     (r_idx),
    .in_range_o(r_in_range)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign ctrl_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
    assign status_arr[g] = status_in[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RDATA = rdata_q;
  assign wr_pulse    = wr_pulse_q;
  assign rd_pulse    = rd_pulse_q;

  // Readies stay low until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  // ---- write channel: state register / next state / outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_state_q <= W_IDLE;
    else     wr_state_q <= wr_state_d;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      W_IDLE: if (aw_full_q && w_full_q) wr_state_d = W_RESP;
      W_RESP: if (S_AXI_BREADY)          wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = ready_en_q && !aw_full_q;
    S_AXI_WREADY  = ready_en_q && !w_full_q;
    S_AXI_BVALID  = (wr_state_q == W_RESP);
    wr_commit     = (wr_state_q == W_IDLE) && aw_full_q && w_full_q;
    b_done        = S_AXI_BVALID && S_AXI_BREADY;
  end

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign aw_full_d = b_done ? 1'b0 : (aw_full_q || aw_hs);
  assign w_full_d  = b_done ? 1'b0 : (w_full_q || w_hs);

  // Holds are only released once the response has been taken, which keeps
  // AW/W back-pressured for the whole response phase.
  always_comb begin
    w_resp = RESP_OKAY;
    if (!w_in_range)         w_resp = RESP_DECERR;
    else if (RO_MASK[w_idx]) w_resp = RESP_SLVERR;

    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    if (wr_commit) begin
      bresp_d = w_resp;
      if (w_resp == RESP_OKAY) begin
        wr_pulse_d[w_idx] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) regs_d[w_idx][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  // ---- read channel: state register / next state / outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state_q <= R_IDLE;
    else     rd_state_q <= rd_state_d;
  end

  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE: if (ar_hs)        rd_state_d = R_DATA;
      R_DATA: if (S_AXI_RREADY) rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = ready_en_q && (rd_state_q == R_IDLE);
    S_AXI_RVALID  = (rd_state_q == R_DATA);
  end

  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Reads see regs_q before any same-edge commit, so they return the old value.
  always_comb begin
    r_resp  = RESP_OKAY;
    r_value = regs_q[r_idx];
    if (!r_in_range) begin
      r_resp  = RESP_DECERR;
      r_value = '0;
    end else if (RO_MASK[r_idx]) begin
      r_value = status_arr[r_idx];
    end

    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    if (ar_hs) begin
      rdata_d = r_value;
      rresp_d = r_resp;
      if (r_resp == RESP_OKAY) rd_pulse_d[r_idx] = 1'b1;
    end
  end

  // ---- registered state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end else begin
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      wdata_q <= S_AXI_WDATA;
      wstrb_q <= S_AXI_WSTRB;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Bench for axi_lite_reg_bank: directed scenarios plus random traffic checked
// against a word-indexed register model.
module tb_axi_lite_reg_bank;

  localparam int NREG = 8;
  localparam logic [NREG-1:0] RO = 8'b0000_0100;
  localparam logic [NREG*32-1:0] RV = {32'h8000_0007, 32'h6000_0006, 32'h0000_0000,
                                       32'h4444_0004, 32'h0303_0303, 32'h5A5A_0002,
                                       32'h1122_3344, 32'h0000_0000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic [NREG*32-1:0] ctrl_out, status_in;
  logic [NREG-1:0]    wr_pulse, rd_pulse;

  logic [NREG-1:0][31:0] mreg;
  logic [NREG-1:0][31:0] status;
  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] d;
  logic [1:0]  r, resp;

  assign status_in = status;

  always #5 clk = ~clk;

  axi_lite_reg_bank #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .NUM_REGS      (NREG),
    .RO_MASK       (RO),
    .RESET_VALUE   (RV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .ctrl_out     (ctrl_out),
    .status_in    (status_in),
    .wr_pulse     (wr_pulse),
    .rd_pulse     (rd_pulse)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Word index of a byte address; anything past the last register is a decode error.
  function automatic int unsigned word_of(input logic [31:0] addr);
    return addr >> 2;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int bdly,
                           output logic [1:0] resp_o);
    logic [NREG-1:0][31:0] nreg;
    logic [1:0]      er;
    logic [NREG-1:0] ep;
    int unsigned     idx;
    int              aw_start, w_start, cyc, n;
    bit              aw_done, w_done, aw_hs, w_hs;
    idx  = word_of(addr);
    nreg = mreg;
    ep   = '0;
    if (idx >= NREG)  er = 2'b11;
    else if (RO[idx]) er = 2'b10;
    else begin
      er = 2'b00;
      ep[idx] = 1'b1;
      for (int b = 0; b < 4; b++) if (strb[b]) nreg[idx][8*b +: 8] = data[8*b +: 8];
    end
    aw_start = (w_lead > 0) ? w_lead : 0;
    w_start  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; cyc = 0; resp_o = 2'b01;
    @(posedge clk); #1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done) && cyc <= 40) begin
      S_AXI_AWVALID = !aw_done && (cyc >= aw_start);
      S_AXI_WVALID  = !w_done && (cyc >= w_start);
      @(negedge clk);
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    if (!(aw_done && w_done)) return;
    n = 0;
    forever begin
      @(negedge clk);
      if (S_AXI_BVALID || n > 20) break;
      n++;
      @(posedge clk); #1;
    end
    chk("b_latency", n, 1);
    if (!S_AXI_BVALID) return;
    resp_o = S_AXI_BRESP;
    chk("bresp", S_AXI_BRESP, er);
    chk("wr_pulse", wr_pulse, ep);
    chk("ctrl_out", ctrl_out, nreg);
    for (int k = 0; k < bdly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("b_hold", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse},
          {1'b1, er, 2'b00, 8'h00});
    end
    S_AXI_BREADY = 1;
    @(posedge clk); #1;
    S_AXI_BREADY = 0;
    @(negedge clk);
    chk("b_done", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse}, {1'b0, 2'b11, 8'h00});
    mreg = nreg;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int rdly,
                          output logic [31:0] data_o, output logic [1:0] resp_o);
    int unsigned     idx;
    logic [31:0]     ed;
    logic [1:0]      er;
    logic [NREG-1:0] ep;
    int              n;
    idx = word_of(addr);
    ep = '0; ed = '0; er = 2'b11;
    data_o = '0; resp_o = 2'b01;
    if (idx < NREG) begin
      er = 2'b00;
      ep[idx] = 1'b1;
      ed = RO[idx] ? status[idx] : mreg[idx];
    end
    @(posedge clk); #1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
    n = 0;
    forever begin
      @(negedge clk);
      if (S_AXI_ARREADY || n > 20) break;
      n++;
      @(posedge clk); #1;
    end
    chk("ar_accept", S_AXI_ARREADY, 1'b1);
    if (!S_AXI_ARREADY) begin
      S_AXI_ARVALID = 0;
      return;
    end
    @(posedge clk); #1;
    S_AXI_ARVALID = 0;
    @(negedge clk);
    data_o = S_AXI_RDATA;
    resp_o = S_AXI_RRESP;
    chk("r_valid", S_AXI_RVALID, 1'b1);
    chk("rdata", S_AXI_RDATA, ed);
    chk("rresp", S_AXI_RRESP, er);
    chk("rd_pulse", rd_pulse, ep);
    for (int k = 0; k < rdly; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("r_hold", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, S_AXI_ARREADY, rd_pulse},
          {1'b1, er, ed, 1'b0, 8'h00});
    end
    S_AXI_RREADY = 1;
    @(posedge clk); #1;
    S_AXI_RREADY = 0;
    @(negedge clk);
    chk("r_done", {S_AXI_RVALID, S_AXI_ARREADY, rd_pulse}, {1'b0, 1'b1, 8'h00});
  endtask

  initial begin
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 0;
    mreg = RV;
    status = '0;
    status[2] = 32'hDEAD_BEEF;

    #3 rst = 1;
    #1;
    chk("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_ctrl", ctrl_out, RV);
    chk("rst_pulse", {wr_pulse, rd_pulse}, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    #1 chk("ready_held", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    @(posedge clk); #1;
    chk("ready_up", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    axi_write(32'h00, 32'hA5A5_0001, 4'hF, 0, 0, resp);
    chk("t1_bresp", resp, 2'b00);
    chk("t1_reg0", ctrl_out[31:0], 32'hA5A5_0001);

    axi_write(32'h04, 32'h0000_BE00, 4'b0010, 3, 0, resp);
    chk("t2_bresp", resp, 2'b00);
    chk("t2_reg1", ctrl_out[63:32], 32'h1122_BE44);

    axi_read(32'h08, 0, d, r);
    chk("t3_rdata", d, 32'hDEAD_BEEF);
    chk("t3_rresp", r, 2'b00);
    axi_write(32'h08, 32'h1234_5678, 4'hF, 0, 0, resp);
    chk("t3_bresp", resp, 2'b10);
    chk("t3_ctrl2", ctrl_out[95:64], 32'h5A5A_0002);

    axi_read(32'h20, 0, d, r);
    chk("t4_rresp", r, 2'b11);
    chk("t4_rdata", d, 32'h0);
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
    chk("t4_bresp", resp, 2'b11);

    axi_write(32'h0C, 32'hCAFE_F00D, 4'hF, -2, 5, resp);
    axi_read(32'h0C, 5, d, r);
    chk("t5_rdata", d, 32'hCAFE_F00D);

    axi_write(32'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, resp);
    chk("t6_bresp", resp, 2'b00);
    chk("t6_reg3", ctrl_out[127:96], 32'hCAFE_F00D);

    fork
      axi_write(32'h04, 32'h7777_8888, 4'hF, 0, 0, resp);
      begin
        @(posedge clk);
        axi_read(32'h04, 0, d, r);
      end
    join
    chk("t7_old", d, 32'h1122_BE44);
    chk("t7_new", ctrl_out[63:32], 32'h7777_8888);

    for (int it = 0; it < 40; it++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = sel * 4;
      else if (sel == 8) a = 32'h20 + 4 * $urandom_range(0, 7);
      else               a = 32'h1000_0000;
      a = a | $urandom_range(0, 3);
      for (int k = 0; k < NREG; k++) status[k] = $urandom();
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom(), 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)), resp);
      else
        axi_read(a, int'($urandom_range(0, 3)), d, r);
    end

    @(posedge clk); #1;
    S_AXI_AWADDR = 32'h10; S_AXI_WDATA = 32'h0BAD_0BAD; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t9_pending", S_AXI_BVALID, 1'b1);
    #2 rst = 1;
    #1;
    chk("t9_bvalid", S_AXI_BVALID, 1'b0);
    chk("t9_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("t9_ctrl", ctrl_out, RV);
    mreg = RV;
    @(negedge clk); rst = 0;
    #1 chk("t9_ready_held", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    @(posedge clk); #1;
    chk("t9_ready_up", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    axi_read(32'h04, 0, d, r);
    chk("t9_reg1", d, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
